// File: rtl/bcd_operand_entry.sv
// Operand entry front-end for the two-digit BCD adder.
// The user keys in two 2-digit operands one digit at a time. Each digit is
// taken from digit_in when the debounced enter button is pressed. Digits
// above 9 are rejected and flagged on err. The debounced clear button wipes
// the entry and takes priority over enter.
module bcd_operand_entry #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [3:0] digit_in,
    input  logic       key_enter_n,
    input  logic       key_clear_n,
    output logic [3:0] op_a_tens,
    output logic [3:0] op_a_ones,
    output logic [3:0] op_b_tens,
    output logic [3:0] op_b_ones,
    output logic       operands_valid,
    output logic [2:0] entry_phase,
    output logic       err
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ENTER_A1 = 3'd0;
    localparam logic [2:0] ENTER_A0 = 3'd1;
    localparam logic [2:0] ENTER_B1 = 3'd2;
    localparam logic [2:0] ENTER_B0 = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    // Bit 0 is enter and bit 1 is clear. Both buttons use the same conditioning.
    logic [1:0] key_raw;
    logic [1:0] press;

    assign key_raw = {key_clear_n, key_enter_n};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic             sync1_q;
            logic             sync2_q;
            logic             stable_q;
            logic             press_q;
            logic [CNT_W-1:0] cnt_q;

            // Synchronize the raw level, then accept a change only after it has held long enough.
            // The press pulse is registered on the edge where stable goes from 1 to 0.
            always_ff @(posedge CLOCK_50) begin
                if (!resetn) begin
                    sync1_q  <= 1'b1;
                    sync2_q  <= 1'b1;
                    stable_q <= 1'b1;
                    press_q  <= 1'b0;
                    cnt_q    <= '0;
                end else begin
                    sync1_q <= key_raw[gi];
                    sync2_q <= sync1_q;
                    press_q <= 1'b0;
                    if (sync2_q == stable_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        stable_q <= sync2_q;
                        cnt_q    <= '0;
                        press_q  <= ~sync2_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end

            assign press[gi] = press_q;
        end
    endgenerate

    logic [2:0] state_q, state_d;
    logic [3:0] a_tens_q, a_tens_d;
    logic [3:0] a_ones_q, a_ones_d;
    logic [3:0] b_tens_q, b_tens_d;
    logic [3:0] b_ones_q, b_ones_d;
    logic       err_q, err_d;
    logic       valid_q, valid_d;
    logic       enter_ev;
    logic       clear_ev;
    logic       digit_ok;

    assign enter_ev = press[0];
    assign clear_ev = press[1];
    assign digit_ok = (digit_in <= 4'd9);

    // Entry sequencing: clear beats enter, and invalid digits only raise err.
    always_comb begin
        state_d  = state_q;
        a_tens_d = a_tens_q;
        a_ones_d = a_ones_q;
        b_tens_d = b_tens_q;
        b_ones_d = b_ones_q;
        err_d    = err_q;
        if (clear_ev) begin
            state_d  = ENTER_A1;
            a_tens_d = 4'd0;
            a_ones_d = 4'd0;
            b_tens_d = 4'd0;
            b_ones_d = 4'd0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                ENTER_A1, ENTER_A0, ENTER_B1, ENTER_B0, DONE: begin
                    if (enter_ev) begin
                        if (!digit_ok) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = 1'b0;
                            case (state_q)
                                ENTER_A1: begin a_tens_d = digit_in; state_d = ENTER_A0; end
                                ENTER_A0: begin a_ones_d = digit_in; state_d = ENTER_B1; end
                                ENTER_B1: begin b_tens_d = digit_in; state_d = ENTER_B0; end
                                ENTER_B0: begin b_ones_d = digit_in; state_d = DONE;     end
                                default: begin
                                    // A new entry starts from DONE with the remaining digits cleared.
                                    a_tens_d = digit_in;
                                    a_ones_d = 4'd0;
                                    b_tens_d = 4'd0;
                                    b_ones_d = 4'd0;
                                    state_d  = ENTER_A0;
                                end
                            endcase
                        end
                    end
                end
                default: state_d = ENTER_A1;
            endcase
        end
        valid_d = (state_d == DONE);
    end

    // State and operand registers. valid is registered from the next state, so it stays in step with state.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q  <= ENTER_A1;
            a_tens_q <= 4'd0;
            a_ones_q <= 4'd0;
            b_tens_q <= 4'd0;
            b_ones_q <= 4'd0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_tens_q <= a_tens_d;
            a_ones_q <= a_ones_d;
            b_tens_q <= b_tens_d;
            b_ones_q <= b_ones_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

    assign op_a_tens      = a_tens_q;
    assign op_a_ones      = a_ones_q;
    assign op_b_tens      = b_tens_q;
    assign op_b_ones      = b_ones_q;
    assign operands_valid = valid_q;
    assign entry_phase    = state_q;
    assign err            = err_q;

endmodule
